// File: rtl/irq_pkg.sv
// Shared constants and types for the interrupt dispatcher.
package irq_pkg;

  localparam int NIRQ = 16;

  localparam logic [1:0] CFG_MASK = 2'd0;
  localparam logic [1:0] CFG_EDGE = 2'd1;
  localparam logic [1:0] CFG_EOI  = 2'd2;
  localparam logic [1:0] CFG_SETP = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } irq_state_t;

endpackage

// File: rtl/irq_prio_sel.sv
// Combinational priority search: first set request at or after i_start, wrapping 15 -> 0.
module irq_prio_sel
  import irq_pkg::*;
(
  input  logic [NIRQ-1:0] i_req,
  input  logic [3:0]      i_start,
  output logic            o_found,
  output logic [3:0]      o_index
);

  logic [3:0] w_idx;

  always_comb begin
    o_found = 1'b0;
    o_index = '0;
    w_idx   = '0;
    for (int i = 0; i < NIRQ; i++) begin
      w_idx = i_start + 4'(i);
      if (!o_found && i_req[w_idx]) begin
        o_found = 1'b1;
        o_index = w_idx;
      end
    end
  end

endmodule

// File: rtl/irq_dispatch.sv
// 16-source interrupt dispatcher issuing single-cycle irqload pulses with holdoff and EOI lock.
// Define IRQ_ROUND_ROBIN_EN for rotating priority; otherwise source 0 always has top priority.
module irq_dispatch
  import irq_pkg::*;
#(
  parameter int          HOLDOFF  = 8,
  parameter logic [15:0] RST_MASK = 16'hFFFF
)
(
  input  logic            clk,
  input  logic            rst,
  input  logic [NIRQ-1:0] irq_in,
  input  logic            cfg_we,
  input  logic [1:0]      cfg_addr,
  input  logic [15:0]     cfg_wdata,
  output logic            irqload,
  output logic [3:0]      irqnum,
  output logic            in_service,
  output logic [NIRQ-1:0] pending
);

  // state | meaning
  // IDLE  | looking for an eligible source
  // ISSUE | irqload high for one cycle, winner's pending bit cleared
  // WAIT  | holdoff countdown, and lock until EOI
  irq_state_t      r_state;
  irq_state_t      w_state_nxt;
  logic [7:0]      r_cnt;
  logic [NIRQ-1:0] r_mask;
  logic [NIRQ-1:0] r_edge;
  logic [NIRQ-1:0] r_prev;
  logic [NIRQ-1:0] r_pend;
  logic            r_load;
  logic [3:0]      r_num;
  logic            r_insvc;

  logic [NIRQ-1:0] w_elig;
  logic [NIRQ-1:0] w_set;
  logic [NIRQ-1:0] w_clr;
  logic            w_found;
  logic [3:0]      w_win;
  logic [3:0]      w_start;
  logic            w_eoi;

`ifdef IRQ_ROUND_ROBIN_EN
  logic [3:0] r_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (r_state == ISSUE) begin
      r_ptr <= r_num + 4'd1;
    end
  end

  assign w_start = r_ptr;
`else
  assign w_start = '0;
`endif

  assign w_elig = r_pend & ~r_mask;

  irq_prio_sel u_sel (
    .i_req   (w_elig),
    .i_start (w_start),
    .o_found (w_found),
    .o_index (w_win)
  );

  // New requests are ORed in after the issue clear, so a same-cycle set keeps the bit pending.
  assign w_set = (r_edge & irq_in & ~r_prev)
               | (~r_edge & irq_in)
               | ((cfg_we && cfg_addr == CFG_SETP) ? cfg_wdata : '0);
  assign w_clr = (r_state == ISSUE) ? (16'd1 << r_num) : '0;
  assign w_eoi = cfg_we && (cfg_addr == CFG_EOI) && r_insvc && (cfg_wdata[3:0] == r_num);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_found) w_state_nxt = ISSUE;
      ISSUE:   w_state_nxt = WAIT;
      WAIT:    if (r_cnt == '0 && !r_insvc) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_mask  <= RST_MASK;
      r_edge  <= '0;
      r_prev  <= '0;
      r_pend  <= '0;
      r_load  <= 1'b0;
      r_num   <= '0;
      r_insvc <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_load  <= (w_state_nxt == ISSUE);
      r_prev  <= irq_in;
      r_pend  <= (r_pend & ~w_clr) | w_set;

      if (r_state == IDLE && w_found) begin
        r_num <= w_win;
      end

      if (r_state == ISSUE) begin
        r_cnt <= 8'(HOLDOFF - 1);
      end else if (r_state == WAIT && r_cnt != '0) begin
        r_cnt <= r_cnt - 8'd1;
      end

      if (r_state == ISSUE) begin
        r_insvc <= 1'b1;
      end else if (w_eoi) begin
        r_insvc <= 1'b0;
      end

      if (cfg_we && cfg_addr == CFG_MASK) begin
        r_mask <= cfg_wdata;
      end
      if (cfg_we && cfg_addr == CFG_EDGE) begin
        r_edge <= cfg_wdata;
      end
    end
  end

  assign irqload    = r_load;
  assign irqnum     = r_num;
  assign in_service = r_insvc;
  assign pending    = r_pend;

endmodule

// File: tb/tb_irq_dispatch.sv
// Self-checking bench for irq_dispatch: directed scenarios plus random traffic against a cycle-level reference model.
module tb_irq_dispatch;
  import irq_pkg::*;

  localparam int HOLDOFF = 8;

  logic        clk;
  logic        rst;
  logic [15:0] irq_in;
  logic        cfg_we;
  logic [1:0]  cfg_addr;
  logic [15:0] cfg_wdata;
  logic        irqload;
  logic [3:0]  irqnum;
  logic        in_service;
  logic [15:0] pending;

  irq_dispatch #(
    .HOLDOFF  (HOLDOFF),
    .RST_MASK (16'hFFFF)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .irq_in     (irq_in),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_wdata  (cfg_wdata),
    .irqload    (irqload),
    .irqnum     (irqnum),
    .in_service (in_service),
    .pending    (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int g_cyc = 0;

  // reference model: values visible during the current cycle
  int          m_cyc = 0;
  int          m_last = -1000;
  logic        m_ld = 1'b0;
  logic [3:0]  m_num = 4'd0;
  logic        m_isv = 1'b0;
  logic        m_isv_prev = 1'b0;
  logic [15:0] m_pend = 16'd0;
  logic [15:0] m_mask = 16'hFFFF;
  logic [15:0] m_edge = 16'd0;
  logic [15:0] m_prev = 16'd0;
  logic [3:0]  m_ptr = 4'd0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, g_cyc);
    end
  endtask

  function automatic logic [3:0] pick(input logic [15:0] v, input logic [3:0] start);
    for (int k = 0; k < 16; k++) begin
      int j;
      j = (int'(start) + k) % 16;
      if (v[j]) return 4'(j);
    end
    return 4'd0;
  endfunction

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    logic [15:0] elig, setv, clrv;
    logic        idle, n_ld, n_isv;
    logic [3:0]  n_num, start;
    if (rst) begin
      m_ld = 1'b0; m_num = 4'd0; m_isv = 1'b0; m_isv_prev = 1'b0;
      m_pend = 16'd0; m_mask = 16'hFFFF; m_edge = 16'd0; m_prev = 16'd0;
      m_ptr = 4'd0; m_last = -1000;
    end else begin
`ifdef IRQ_ROUND_ROBIN_EN
      start = m_ptr;
`else
      start = 4'd0;
`endif
      elig  = m_pend & ~m_mask;
      // free to decide once holdoff has elapsed and the previous cycle had no interrupt in service
      idle  = !m_ld && (m_cyc >= m_last + HOLDOFF + 1) && !m_isv_prev;
      n_ld  = idle && (elig != 16'd0);
      n_num = n_ld ? pick(elig, start) : m_num;
      setv  = (m_edge & irq_in & ~m_prev) | (~m_edge & irq_in);
      if (cfg_we && cfg_addr == CFG_SETP) setv = setv | cfg_wdata;
      clrv  = m_ld ? (16'd1 << m_num) : 16'd0;
      n_isv = m_isv;
      if (m_ld) begin
        n_isv  = 1'b1;
        m_last = m_cyc;
        m_ptr  = m_num + 4'd1;
      end else if (cfg_we && cfg_addr == CFG_EOI && m_isv && cfg_wdata[3:0] == m_num) begin
        n_isv = 1'b0;
      end
      if (cfg_we && cfg_addr == CFG_MASK) m_mask = cfg_wdata;
      if (cfg_we && cfg_addr == CFG_EDGE) m_edge = cfg_wdata;
      m_pend     = (m_pend & ~clrv) | setv;
      m_prev     = irq_in;
      m_isv_prev = m_isv;
      m_isv      = n_isv;
      m_ld       = n_ld;
      m_num      = n_num;
    end
    m_cyc++;
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    @(negedge clk);
    g_cyc++;
    rst    = 1'b0;
    cfg_we = 1'b0;
    chk("irqload", 32'(irqload), 32'(m_ld));
    chk("in_service", 32'(in_service), 32'(m_isv));
    chk("pending", 32'(pending), 32'(m_pend));
    if (m_ld) chk("irqnum", 32'(irqnum), 32'(m_num));
  endtask

  task automatic cfg(input logic [1:0] a, input logic [15:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    step();
  endtask

  task automatic wait_load(input string tag, input int max, output int n);
    n = 0;
    while (n < max) begin
      step();
      n++;
      if (irqload) return;
    end
    chk({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic count_loads(input int cycles, output int cnt);
    cnt = 0;
    for (int k = 0; k < cycles; k++) begin
      step();
      if (irqload) cnt++;
    end
  endtask

  task automatic init_cfg(input logic [15:0] edges);
    rst = 1'b1; irq_in = 16'd0;
    step();
    chk("rst_irqload", 32'(irqload), 32'd0);
    chk("rst_irqnum", 32'(irqnum), 32'd0);
    chk("rst_in_service", 32'(in_service), 32'd0);
    chk("rst_pending", 32'(pending), 32'd0);
    cfg(CFG_MASK, 16'h0000);
    cfg(CFG_EDGE, edges);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, c, t0;
    logic [3:0] order [4];
    rst = 1'b1; irq_in = 16'd0; cfg_we = 1'b0; cfg_addr = 2'd0; cfg_wdata = 16'd0;
    step();

    // single edge pulse on source 5
    init_cfg(16'h026C);
    irq_in = 16'h0020; step(); irq_in = 16'h0000;
    wait_load("t1", 20, n);
    chk("t1_latency", 32'(n), 32'd1);
    chk("t1_num", 32'(irqnum), 32'd5);
    step();
    cfg(CFG_EOI, 16'd5);
    chk("t1_eoi", 32'(in_service), 32'd0);
    count_loads(30, c);
    chk("t1_no_repeat", 32'(c), 32'd0);

    // simultaneous edges on 3 and 9
    init_cfg(16'h026C);
    irq_in = 16'h0208; step(); irq_in = 16'h0000;
    wait_load("t2a", 20, n);
    chk("t2_first", 32'(irqnum), 32'd3);
    t0 = g_cyc;
    step();
    cfg(CFG_EOI, 16'd3);
    wait_load("t2b", 40, n);
    chk("t2_second", 32'(irqnum), 32'd9);
    chk("t2_spacing", 32'((g_cyc - t0) >= HOLDOFF + 1), 32'd1);
    step();
    cfg(CFG_EOI, 16'd9);

    // level source 7 re-issues after EOI while held
    init_cfg(16'h026C);
    irq_in = 16'h0080;
    wait_load("t3a", 20, n);
    chk("t3_first", 32'(irqnum), 32'd7);
    step();
    cfg(CFG_EOI, 16'd7);
    wait_load("t3b", 40, n);
    chk("t3_reissue", 32'(irqnum), 32'd7);
    irq_in = 16'h0000;
    step();
    chk("t3_pend_clear", 32'(pending[7]), 32'd0);
    cfg(CFG_EOI, 16'd7);
    count_loads(30, c);
    chk("t3_no_more", 32'(c), 32'd0);

    // masked edge is held pending, issued after unmask
    init_cfg(16'h026C);
    cfg(CFG_MASK, 16'h0004);
    irq_in = 16'h0004; step(); irq_in = 16'h0000;
    count_loads(10, c);
    chk("t4_masked", 32'(c), 32'd0);
    chk("t4_held", 32'(pending[2]), 32'd1);
    cfg(CFG_MASK, 16'h0000);
    wait_load("t4", 5, n);
    chk("t4_latency", 32'(n), 32'd1);
    chk("t4_num", 32'(irqnum), 32'd2);
    step();
    cfg(CFG_EOI, 16'd2);

    // set-pending racing the issue clear, wrong EOI, reset mid-WAIT
    init_cfg(16'h026C);
    irq_in = 16'h0040; step(); irq_in = 16'h0000;
    wait_load("t5", 20, n);
    chk("t5_num", 32'(irqnum), 32'd6);
    cfg(CFG_SETP, 16'h0040);
    chk("t5_set_wins", 32'(pending[6]), 32'd1);
    cfg(CFG_EOI, 16'd4);
    step();
    chk("t5_wrong_eoi", 32'(in_service), 32'd1);
    count_loads(12, c);
    chk("t5_locked", 32'(c), 32'd0);
    rst = 1'b1;
    step();
    chk("t5_rst_irqload", 32'(irqload), 32'd0);
    chk("t5_rst_irqnum", 32'(irqnum), 32'd0);
    chk("t5_rst_in_service", 32'(in_service), 32'd0);
    chk("t5_rst_pending", 32'(pending), 32'd0);

`ifdef IRQ_ROUND_ROBIN_EN
    init_cfg(16'h0000);
    irq_in = 16'h0006;
    for (int k = 0; k < 4; k++) begin
      wait_load("rr", 40, n);
      order[k] = irqnum;
      step();
      cfg(CFG_EOI, {12'd0, order[k]});
    end
    chk("rr_0", 32'(order[0]), 32'd1);
    chk("rr_1", 32'(order[1]), 32'd2);
    chk("rr_2", 32'(order[2]), 32'd1);
    chk("rr_3", 32'(order[3]), 32'd2);
    irq_in = 16'h0000;
`else
    order[0] = 4'd0;
`endif

    // random traffic
    init_cfg(16'($urandom));
    for (int it = 0; it < 3000; it++) begin
      int r;
      if ($urandom_range(0, 3) == 0) irq_in = 16'($urandom & $urandom & $urandom);
      r = $urandom_range(0, 199);
      if (r < 16) begin
        cfg_we = 1'b1; cfg_addr = CFG_EOI; cfg_wdata = {12'($urandom), m_num};
      end else if (r < 20) begin
        cfg_we = 1'b1; cfg_addr = CFG_EOI; cfg_wdata = 16'($urandom);
      end else if (r < 24) begin
        cfg_we = 1'b1; cfg_addr = CFG_MASK; cfg_wdata = 16'($urandom & $urandom);
      end else if (r < 27) begin
        cfg_we = 1'b1; cfg_addr = CFG_EDGE; cfg_wdata = 16'($urandom);
      end else if (r < 32) begin
        cfg_we = 1'b1; cfg_addr = CFG_SETP; cfg_wdata = 16'($urandom & $urandom & $urandom);
      end else if (r == 199) begin
        rst = 1'b1;
      end
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
